seq_det_param: RTL and testbench



---
 rtl/seq_det_param_if.sv | 26 ++
 rtl/seq_det_param.sv | 121 ++++++++++++
 tb/tb_seq_det_param.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/seq_det_param_if.sv
// Bundles the serial-bit stream, pattern load and match status of seq_det_param.
// master drives the stream and configuration, slave is the detector.
interface seq_det_param_if #(
  parameter int N     = 4,
  parameter int CNT_W = 8
);
  logic             x;
  logic             x_valid;
  logic             load;
  logic [N-1:0]     pattern;
  logic             overlap;
  logic             y;
  logic             armed;
  logic [CNT_W-1:0] match_cnt;
  logic             cnt_sat;

  modport master (
    output x, x_valid, load, pattern, overlap,
    input  y, armed, match_cnt, cnt_sat
  );

  modport slave (
    input  x, x_valid, load, pattern, overlap,
    output y, armed, match_cnt, cnt_sat
  );
endinterface

// File: rtl/seq_det_param.sv
// Parametrised serial pattern detector with overlap control and saturating match counter.
// Optional idle-gap restart is enabled by defining SEQ_DET_GAP_RESET_EN.
module seq_det_param #(
  parameter int           N           = 4,
  parameter int           CNT_W       = 8,
  parameter logic [N-1:0] RST_PATTERN = {N{1'b1}},
  parameter int           GAP_MAX     = 15
) (
  input logic             clk,
  input logic             reset,
  seq_det_param_if.slave  bus
);

  localparam int FW = $clog2(N + 1);
  localparam logic [FW-1:0] FULL = FW'(N);

  typedef enum logic {FILL, ARMED} state_t;

  if (N < 2 || N > 32 || GAP_MAX < 1) begin : g_bad_param
    $error("seq_det_param: illegal parameter value");
  end

  state_t           state, state_d;
  logic [N-1:0]     history, history_d, history_n;
  logic [N-1:0]     pat_reg, pat_d;
  logic [FW-1:0]    fill, fill_d, fill_n;
  logic             y_q, y_d;
  logic [CNT_W-1:0] match_cnt, cnt_d;
  logic             cnt_sat, sat_d;
  logic             hit;

`ifdef SEQ_DET_GAP_RESET_EN
  localparam int IW = $clog2(GAP_MAX + 1);
  localparam logic [IW-1:0] GAP_LIM = IW'(GAP_MAX);
  logic [IW-1:0] idle, idle_d;
`endif

  always_comb begin
    history_n = {history[N-2:0], bus.x};
    fill_n    = (fill == FULL) ? FULL : fill + 1'b1;
    hit       = bus.x_valid && (fill_n == FULL) && (history_n == pat_reg);

    state_d   = state;
    history_d = history;
    fill_d    = fill;
    pat_d     = pat_reg;
    y_d       = 1'b0;
    cnt_d     = match_cnt;
`ifdef SEQ_DET_GAP_RESET_EN
    idle_d    = '0;
`endif

    if (bus.load) begin
      pat_d     = bus.pattern;
      history_d = '0;
      fill_d    = '0;
      state_d   = FILL;
    end else if (bus.x_valid) begin
      history_d = history_n;
      y_d       = hit;
      // Non-overlapping mode discards the matched bits and restarts the window
      if (hit && !bus.overlap) begin
        fill_d  = '0;
        state_d = FILL;
      end else begin
        fill_d  = fill_n;
        state_d = (fill_n == FULL) ? ARMED : FILL;
      end
      if (hit && !(&match_cnt)) begin
        cnt_d = match_cnt + 1'b1;
      end
    end else begin
`ifdef SEQ_DET_GAP_RESET_EN
      idle_d = (idle == GAP_LIM) ? idle : idle + 1'b1;
      if (idle_d == GAP_LIM) begin
        history_d = '0;
        fill_d    = '0;
        state_d   = FILL;
      end
`endif
    end

    sat_d = &cnt_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FILL;
      history   <= '0;
      fill      <= '0;
      pat_reg   <= RST_PATTERN;
      y_q       <= 1'b0;
      match_cnt <= '0;
      cnt_sat   <= 1'b0;
    end else begin
      state     <= state_d;
      history   <= history_d;
      fill      <= fill_d;
      pat_reg   <= pat_d;
      y_q       <= y_d;
      match_cnt <= cnt_d;
      cnt_sat   <= sat_d;
    end
  end

`ifdef SEQ_DET_GAP_RESET_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      idle <= '0;
    end else begin
      idle <= idle_d;
    end
  end
`endif

  assign bus.y         = y_q;
  assign bus.armed     = (state == ARMED);
  assign bus.match_cnt = match_cnt;
  assign bus.cnt_sat   = cnt_sat;

endmodule

// File: tb/tb_seq_det_param.sv
// Self-checking bench for seq_det_param: directed scenarios followed by random traffic,
// checked each cycle against a queue-based window model of the detector.
module tb_seq_det_param;

  localparam int           N       = 4;
  localparam int           CNT_W   = 3;
  localparam int           GAP_MAX = 4;
  localparam logic [N-1:0] RST_PAT = '1;
  localparam int           CMAX    = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  seq_det_param_if #(.N(N), .CNT_W(CNT_W)) bus ();

  seq_det_param #(
    .N(N), .CNT_W(CNT_W), .RST_PATTERN(RST_PAT), .GAP_MAX(GAP_MAX)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int           tests = 0;
  int           fails = 0;
  bit           win[$];
  logic [N-1:0] m_pat;
  int           m_cnt;
  logic         m_y;
  int           m_idle;

  // Model: the window holds the valid bits seen since the last restart, newest last
  function automatic void modelStep(input logic r, input logic ld, input logic [N-1:0] p,
                                    input logic xv, input logic xb, input logic ov);
    int v;
    if (r) begin
      win.delete();
      m_pat  = RST_PAT;
      m_cnt  = 0;
      m_y    = 1'b0;
      m_idle = 0;
    end else if (ld) begin
      win.delete();
      m_pat  = p;
      m_y    = 1'b0;
      m_idle = 0;
    end else if (xv) begin
      m_idle = 0;
      win.push_back(xb);
      if (win.size() > N) void'(win.pop_front());
      v = 0;
      foreach (win[i]) v = (v << 1) | int'(win[i]);
      m_y = (win.size() == N) && (v == int'(m_pat));
      if (m_y) begin
        if (m_cnt < CMAX) m_cnt++;
        if (!ov) win.delete();
      end
    end else begin
      m_y = 1'b0;
`ifdef SEQ_DET_GAP_RESET_EN
      if (m_idle < GAP_MAX) m_idle++;
      if (m_idle == GAP_MAX) win.delete();
`endif
    end
  endfunction

  task automatic checkOutput(input string tag);
    logic             exp_armed;
    logic [CNT_W-1:0] exp_cnt;
    logic             exp_sat;
    exp_armed = (win.size() == N);
    exp_cnt   = CNT_W'(m_cnt);
    exp_sat   = (m_cnt == CMAX);
    tests++;
    assert (bus.y === m_y) else begin
      fails++;
      $error("FAIL %s y: got %b expected %b", tag, bus.y, m_y);
    end
    tests++;
    assert (bus.armed === exp_armed) else begin
      fails++;
      $error("FAIL %s armed: got %b expected %b", tag, bus.armed, exp_armed);
    end
    tests++;
    assert (bus.match_cnt === exp_cnt) else begin
      fails++;
      $error("FAIL %s match_cnt: got %0d expected %0d", tag, bus.match_cnt, exp_cnt);
    end
    tests++;
    assert (bus.cnt_sat === exp_sat) else begin
      fails++;
      $error("FAIL %s cnt_sat: got %b expected %b", tag, bus.cnt_sat, exp_sat);
    end
  endtask

  task automatic applyStimulus(input string tag, input logic r, input logic ld,
                               input logic [N-1:0] p, input logic xv, input logic xb,
                               input logic ov);
    @(negedge clk);
    reset       = r;
    bus.load    = ld;
    bus.pattern = p;
    bus.x_valid = xv;
    bus.x       = xb;
    bus.overlap = ov;
    @(posedge clk);
    modelStep(r, ld, p, xv, xb, ov);
    #1;
    checkOutput(tag);
  endtask

  task automatic checkCount(input string tag, input int expected);
    tests++;
    assert (int'(bus.match_cnt) === expected) else begin
      fails++;
      $error("FAIL %s final count: got %0d expected %0d", tag, bus.match_cnt, expected);
    end
  endtask

  task automatic checkY(input string tag, input logic expected);
    tests++;
    assert (bus.y === expected) else begin
      fails++;
      $error("FAIL %s y pulse: got %b expected %b", tag, bus.y, expected);
    end
  endtask

  task automatic runStream(input string tag, input logic ov, input int gap);
    logic [6:0] s;
    s = 7'b1011011;
    for (int i = 6; i >= 0; i--) begin
      applyStimulus(tag, 1'b0, 1'b0, '0, 1'b1, s[i], ov);
      for (int g = 0; g < gap; g++) applyStimulus(tag, 1'b0, 1'b0, '0, 1'b0, 1'b0, ov);
    end
  endtask

  initial begin
    reset = 1'b1; bus.load = 1'b0; bus.pattern = '0;
    bus.x_valid = 1'b0; bus.x = 1'b0; bus.overlap = 1'b1;

    applyStimulus("reset", 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    applyStimulus("reset", 1'b1, 1'b0, '0, 1'b1, 1'b1, 1'b1);

    applyStimulus("ovl_load", 1'b0, 1'b1, 4'b1011, 1'b0, 1'b0, 1'b1);
    runStream("ovl", 1'b1, 0);
    checkCount("ovl", 2);

    applyStimulus("novl_rst", 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    applyStimulus("novl_load", 1'b0, 1'b1, 4'b1011, 1'b0, 1'b0, 1'b0);
    runStream("novl", 1'b0, 0);
    checkCount("novl", 1);

    applyStimulus("gap_rst", 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    applyStimulus("gap_load", 1'b0, 1'b1, 4'b1011, 1'b0, 1'b0, 1'b1);
    runStream("gap3", 1'b1, 3);
    checkCount("gap3", 2);

    applyStimulus("ldx_rst", 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus("ldx_pre", 1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1);
    applyStimulus("ldx_load", 1'b0, 1'b1, 4'b1111, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus("ldx_ones", 1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1);
    checkY("ldx_3rd", 1'b0);
    applyStimulus("ldx_4th", 1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1);
    checkY("ldx_4th", 1'b1);
    applyStimulus("ldx_5th", 1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1);
    checkCount("ldx", 2);

    applyStimulus("sat_rst", 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) applyStimulus("sat", 1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1);
    checkCount("sat", CMAX);

    for (int i = 0; i < 3; i++) applyStimulus("rst_mid", 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1);
    applyStimulus("rst_mid", 1'b1, 1'b0, '0, 1'b1, 1'b1, 1'b1);
    checkCount("rst_mid", 0);
    for (int i = 0; i < 4; i++) applyStimulus("rst_pat", 1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1);
    checkY("rst_pat", 1'b1);

`ifdef SEQ_DET_GAP_RESET_EN
    for (int gap = 4; gap >= 3; gap--) begin
      applyStimulus("gto_rst", 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1);
      applyStimulus("gto_load", 1'b0, 1'b1, 4'b1011, 1'b0, 1'b0, 1'b1);
      applyStimulus("gto", 1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1);
      applyStimulus("gto", 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1);
      applyStimulus("gto", 1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1);
      for (int g = 0; g < gap; g++) applyStimulus("gto_idle", 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
      applyStimulus("gto_last", 1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1);
      checkY("gto_last", (gap == 3));
    end
`endif

    applyStimulus("rnd_rst", 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3000; i++) begin
      logic r, ld, xv, xb, ov;
      logic [N-1:0] p;
      r  = ($urandom_range(999) < 3);
      ld = ($urandom_range(99) < 2);
      xv = ($urandom_range(99) < 75);
      xb = 1'($urandom_range(1));
      ov = ($urandom_range(99) < 60);
      p  = N'($urandom);
      applyStimulus("rnd", r, ld, p, xv, xb, ov);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
